// File: rtl/state_sram_reader.sv
// Streams the initial state plus seq_lens generated states out of the state SRAM over valid/ready.
// Optional running checksum port enabled by defining STATE_SRAM_READER_CHECKSUM_EN.
module state_sram_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STATE_DIM  = 13,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MAX_WORDS  = 780
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5:0]            seq_lens,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_en,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
`ifdef STATE_SRAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam int unsigned CNT_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      n_words, n_words_n;
    logic [CNT_W-1:0]      issue_cnt, issue_cnt_n;
    logic [CNT_W-1:0]      out_idx, out_idx_n;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_cnt, fifo_cnt_n;
    logic                  rd_ptr, rd_ptr_n;
    logic                  wr_ptr, wr_ptr_n;
    logic                  inflight, inflight_n;
    logic [ADDR_WIDTH-1:0] sram_addr_n;
    logic                  sram_en_n;
    logic                  out_valid_n, out_last_n;
    logic                  busy_n, done_n, overflow_n;
    logic                  pop, bypass, pop_fifo, push, can_issue;
    logic [CNT_W-1:0]      req_words;
`ifdef STATE_SRAM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_n;
`endif

    // Head of stream: oldest buffered word, else the read landing this cycle.
    assign out_data = (fifo_cnt != 2'd0) ? fifo_data[rd_ptr]
                    : (inflight ? sram_rdata : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            n_words      <= '0;
            issue_cnt    <= '0;
            out_idx      <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_cnt     <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            inflight     <= 1'b0;
            sram_addr    <= ADDR_WIDTH'(BASE_ADDR);
            sram_en      <= 1'b0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
`ifdef STATE_SRAM_READER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            state     <= state_n;
            n_words   <= n_words_n;
            issue_cnt <= issue_cnt_n;
            out_idx   <= out_idx_n;
            if (push) begin
                fifo_data[wr_ptr] <= sram_rdata;
            end
            fifo_cnt  <= fifo_cnt_n;
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            inflight  <= inflight_n;
            sram_addr <= sram_addr_n;
            sram_en   <= sram_en_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            busy      <= busy_n;
            done      <= done_n;
            overflow  <= overflow_n;
`ifdef STATE_SRAM_READER_CHECKSUM_EN
            checksum  <= checksum_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        n_words_n   = n_words;
        issue_cnt_n = issue_cnt;
        out_idx_n   = out_idx;
        rd_ptr_n    = rd_ptr;
        wr_ptr_n    = wr_ptr;
        sram_addr_n = sram_addr;
        sram_en_n   = 1'b0;
        done_n      = 1'b0;
        overflow_n  = overflow;
`ifdef STATE_SRAM_READER_CHECKSUM_EN
        checksum_n  = checksum;
`endif

        // An empty FIFO with a handshake consumes the landing read word directly.
        pop      = out_valid & out_ready;
        bypass   = pop & (fifo_cnt == 2'd0);
        pop_fifo = pop & ~bypass;
        push     = inflight & ~bypass;
        if (pop_fifo) rd_ptr_n = ~rd_ptr;
        if (push)     wr_ptr_n = ~wr_ptr;
        fifo_cnt_n = fifo_cnt + 2'(push) - 2'(pop_fifo);
        inflight_n = sram_en;

        // Words owed to the consumer (buffered + landing + being read) must stay within 2.
        can_issue = (3'(fifo_cnt) + 3'(inflight) + 3'(sram_en)) < (3'd2 + 3'(pop));

        req_words = CNT_W'((CNT_W'(seq_lens) + CNT_W'(1)) * CNT_W'(STATE_DIM));

        if (pop) begin
            out_idx_n = (out_idx == n_words - CNT_W'(1)) ? '0 : out_idx + CNT_W'(1);
`ifdef STATE_SRAM_READER_CHECKSUM_EN
            checksum_n = checksum + out_data;
`endif
        end

        case (state)
            IDLE: begin
                if (start) begin
                    if (req_words > CNT_W'(MAX_WORDS)) begin
                        n_words_n  = CNT_W'(MAX_WORDS);
                        overflow_n = 1'b1;
                    end else begin
                        n_words_n  = req_words;
                        overflow_n = 1'b0;
                    end
                    sram_en_n   = 1'b1;
                    sram_addr_n = ADDR_WIDTH'(BASE_ADDR);
                    issue_cnt_n = CNT_W'(1);
                    out_idx_n   = '0;
                    state_n     = READ;
`ifdef STATE_SRAM_READER_CHECKSUM_EN
                    checksum_n  = '0;
`endif
                end
            end
            READ: begin
                if (can_issue) begin
                    sram_en_n   = 1'b1;
                    sram_addr_n = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(issue_cnt);
                    issue_cnt_n = issue_cnt + CNT_W'(1);
                    if (issue_cnt == n_words - CNT_W'(1)) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n      = (state_n != IDLE);
        out_valid_n = (fifo_cnt_n != 2'd0) | inflight_n;
        out_last_n  = out_valid_n & (out_idx_n == n_words_n - CNT_W'(1));
    end

endmodule
